// File: rtl/mem_io_bus_pkg.sv
// Shared address-map constants and decode helpers for the memory/I-O responder.
package mem_io_bus_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 17;

    localparam logic [1:0]  IO_BASE    = 2'b11;
    localparam logic [2:0]  IO_CONSOLE = 3'h0;
    localparam logic [2:0]  IO_CLOCK   = 3'h4;
    localparam logic [17:0] RAM_LIMIT  = 18'h20000;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_HOLE = 2'd1,
        REG_IO   = 2'd2
    } region_e;

    // Classify an 18-bit bus address into RAM, unmapped hole or I/O window.
    function automatic region_e decode_region(input logic [17:0] a);
        region_e r;
        if (a[17:16] == IO_BASE) begin
            r = REG_IO;
        end else if (a < RAM_LIMIT) begin
            r = REG_RAM;
        end else begin
            r = REG_HOLE;
        end
        return r;
    endfunction

    // Little-endian byte k of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_io_bus_byte_fifo.sv
// Byte-wide FIFO with wrap-bit pointers; a push into a full FIFO succeeds
// only when a pop happens at the same edge.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic [7:0] wdata,
    output logic       full,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    logic [7:0]  r_mem [0:DEPTH-1];

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Head byte reads as zero while empty so tx_data is clean after reset.
    assign rdata     = empty ? 8'h00 : r_mem[r_rd_ptr[PW-1:0]];

    // Pointer state; reset discards any queued bytes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= {(PW+1){1'b0}};
            r_rd_ptr <= {(PW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mem_io_bus.sv
// Memory/I-O responder: 128 KB byte RAM, unmapped hole, and an I/O window
// holding console RX/TX, a cycle-counter snapshot and a sticky halt flag.
module mem_io_bus
    import mem_io_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned TX_DEPTH   = 8,
    parameter              INIT_FILE  = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] bus_a,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    output logic [7:0]  bus_rdata,
    output logic        bus_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt
);

    logic [7:0] r_ram [0:(1 << ADDR_WIDTH)-1];

    logic [31:0] r_cnt;
    logic [31:0] r_snap;
    logic        r_prev_rd;
    logic [17:0] r_prev_a;
    logic [7:0]  r_rdata;
    logic        r_halt;

    logic [17:0]           w_a;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic [2:0]            w_io_sel;
    region_e               w_region;
    logic                  w_rd;
    logic                  w_repeat;
    logic                  w_con_rd;
    logic                  w_clk_rd;
    logic                  w_snap_fire;
    logic                  w_push;
    logic [7:0]            w_push_data;
    logic                  w_halt_set;
    logic [7:0]            w_rd_byte;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_unused;

    assign w_a       = bus_a[17:0];
    assign w_unused  = ^bus_a[31:18];
    assign w_ram_idx = w_a[ADDR_WIDTH-1:0];
    assign w_io_sel  = w_a[2:0];
    assign w_region  = decode_region(w_a);
    assign w_rd      = !bus_wr;

    // A held read of the same address must not pop or snapshot again.
    assign w_repeat    = r_prev_rd && (r_prev_a == w_a);
    assign w_con_rd    = w_rd && (w_region == REG_IO) && (w_io_sel == IO_CONSOLE);
    assign w_clk_rd    = w_rd && (w_region == REG_IO) && (w_io_sel == IO_CLOCK);
    assign w_snap_fire = w_clk_rd && !w_repeat;
    assign w_halt_set  = bus_wr && (w_region == REG_IO) && (w_io_sel == IO_CLOCK);

    // Pop strobe to the receive source, forced low while in reset.
    assign rx_ready = w_con_rd && !w_repeat && rx_valid && rst_in;

    // Select what a console/clock write pushes into the TX FIFO.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = 8'h00;
        if (bus_wr && (w_region == REG_IO)) begin
            case (w_io_sel)
                IO_CONSOLE: begin
                    w_push      = (bus_wdata != 8'h00);
                    w_push_data = bus_wdata;
                end
                IO_CLOCK: begin
                    w_push      = 1'b1;
                    w_push_data = 8'h00;
                end
                default: begin
                    w_push      = 1'b0;
                    w_push_data = 8'h00;
                end
            endcase
        end else begin
            w_push      = 1'b0;
            w_push_data = 8'h00;
        end
    end

    // Read-data mux across RAM, hole and I/O registers.
    always_comb begin
        w_rd_byte = 8'h00;
        case (w_region)
            REG_RAM: w_rd_byte = r_ram[w_ram_idx];
            REG_IO: begin
                case (w_io_sel)
                    3'h0:    w_rd_byte = rx_valid ? rx_data : 8'h00;
                    3'h4:    w_rd_byte = w_snap_fire ? r_cnt[7:0] : r_snap[7:0];
                    3'h5,
                    3'h6,
                    3'h7:    w_rd_byte = word_byte(r_snap, w_io_sel[1:0]);
                    default: w_rd_byte = 8'h00;
                endcase
            end
            default: w_rd_byte = 8'h00;
        endcase
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (bus_wr && (w_region == REG_RAM)) begin
            r_ram[w_ram_idx] <= bus_wdata;
        end
    end

    // Counter, snapshot, read history, read-data register and halt flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt     <= 32'h0000_0000;
            r_snap    <= 32'h0000_0000;
            r_prev_rd <= 1'b0;
            r_prev_a  <= 18'h00000;
            r_rdata   <= 8'h00;
            r_halt    <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + 32'd1;
            r_prev_rd <= w_rd;
            r_prev_a  <= w_a;
            if (w_snap_fire) begin
                r_snap <= r_cnt;
            end
            if (w_rd) begin
                r_rdata <= w_rd_byte;
            end
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (w_push),
        .wdata  (w_push_data),
        .full   (w_full),
        .pop    (tx_ready),
        .rdata  (tx_data),
        .empty  (w_empty)
    );

    assign bus_rdata = r_rdata;
    assign halt      = r_halt;
    assign bus_rdy   = !w_full;
    assign tx_valid  = !w_empty;

endmodule
